// File: rtl/usb_pkg.sv
// rtl/usb_pkg.sv - line-state and decoder-state types plus SYNC/bit-stuff constants
package usb_pkg;

  typedef enum logic [1:0] {
    LS_J   = 2'd0,
    LS_K   = 2'd1,
    LS_SE0 = 2'd2,
    LS_SE1 = 2'd3
  } line_state_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SYNC     = 3'd1,
    ST_DATA     = 3'd2,
    ST_EOP      = 3'd3,
    ST_ERR_WAIT = 3'd4
  } dec_state_t;

  localparam logic [3:0] SYNC_ZEROS = 4'd7;
  localparam logic [2:0] MAX_ONES   = 3'd6;

  function automatic line_state_t classify(input logic dp, input logic dm);
    case ({dp, dm})
      2'b10:   return LS_J;
      2'b01:   return LS_K;
      2'b00:   return LS_SE0;
      default: return LS_SE1;
    endcase
  endfunction

endpackage

// File: rtl/nrzi_line_dec.sv
// rtl/nrzi_line_dec.sv - line classification and NRZI decode against the last J/K symbol
module nrzi_line_dec
  import usb_pkg::*;
(
  input  logic        clk,
  input  logic        rst_b,
  input  logic        dp,
  input  logic        dm,
  output line_state_t line,
  output logic        dec_bit
);

  line_state_t prev_sym;

  always_comb line = classify(dp, dm);

  // Only meaningful for J/K; SE0/SE1 never disturb the reference symbol.
  always_comb dec_bit = (line == prev_sym);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      prev_sym <= LS_J;
    end else if (line == LS_J || line == LS_K) begin
      prev_sym <= line;
    end
  end

endmodule

// File: rtl/nrzi_dec.sv
// rtl/nrzi_dec.sv - USB-style receive decoder: SYNC detect, unstuff, EOP/error framing
// Bit unstuffing and stuff-violation detection only exist with NRZI_DEC_UNSTUFF_EN defined.
module nrzi_dec
  import usb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_b,
  input  logic       dp,
  input  logic       dm,
  output logic       bstr_out,
  output logic       bstr_out_valid,
  output logic       pkt_start,
  output logic       pkt_end,
  output logic       rx_err,
  output logic       rx_active,
  output logic [5:0] stuffed_out
);

  line_state_t line;
  logic        dec_bit;
  logic        is_jk;

  dec_state_t  state, state_nxt;
  logic [3:0]  zero_cnt, zero_nxt;
  logic [1:0]  se0_cnt, se0_nxt;
  logic        deliver, start_evt, end_evt, err_evt;

`ifdef NRZI_DEC_UNSTUFF_EN
  logic [2:0]  ones_cnt, ones_nxt;
  logic        drop;
  logic [5:0]  stuffed_q;
`endif

  nrzi_line_dec u_line_dec (
    .clk     (clk),
    .rst_b   (rst_b),
    .dp      (dp),
    .dm      (dm),
    .line    (line),
    .dec_bit (dec_bit)
  );

  assign is_jk = (line == LS_J) || (line == LS_K);

  always_comb begin
    state_nxt = state;
    zero_nxt  = zero_cnt;
    se0_nxt   = se0_cnt;
    deliver   = 1'b0;
    start_evt = 1'b0;
    end_evt   = 1'b0;
    err_evt   = 1'b0;
`ifdef NRZI_DEC_UNSTUFF_EN
    ones_nxt  = ones_cnt;
    drop      = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (line == LS_K) begin
          state_nxt = ST_SYNC;
          zero_nxt  = 4'd1;
        end
      end
      ST_SYNC: begin
        if (!is_jk) begin
          state_nxt = ST_IDLE;
        end else if (!dec_bit) begin
          if (zero_cnt != 4'hF) zero_nxt = zero_cnt + 4'd1;
        end else if (zero_cnt == SYNC_ZEROS) begin
          state_nxt = ST_DATA;
          start_evt = 1'b1;
`ifdef NRZI_DEC_UNSTUFF_EN
          // The SYNC's closing 1 starts the run of ones.
          ones_nxt  = 3'd1;
`endif
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (line == LS_SE0) begin
          state_nxt = ST_EOP;
          se0_nxt   = 2'd1;
        end else if (line == LS_SE1) begin
          state_nxt = ST_ERR_WAIT;
          err_evt   = 1'b1;
          se0_nxt   = 2'd0;
        end else begin
`ifdef NRZI_DEC_UNSTUFF_EN
          if (ones_cnt == MAX_ONES) begin
            if (!dec_bit) begin
              drop     = 1'b1;
              ones_nxt = 3'd0;
            end else begin
              state_nxt = ST_ERR_WAIT;
              err_evt   = 1'b1;
              se0_nxt   = 2'd0;
            end
          end else begin
            deliver  = 1'b1;
            ones_nxt = dec_bit ? ones_cnt + 3'd1 : 3'd0;
          end
`else
          deliver = 1'b1;
`endif
        end
      end
      ST_EOP: begin
        if (line == LS_SE0) begin
          if (se0_cnt != 2'd3) se0_nxt = se0_cnt + 2'd1;
        end else begin
          state_nxt = ST_IDLE;
          end_evt   = 1'b1;
          // A lone SE0 before J is as malformed as K or SE1 here.
          err_evt   = (line != LS_J) || (se0_cnt < 2'd2);
        end
      end
      ST_ERR_WAIT: begin
        if (line == LS_SE0) begin
          if (se0_cnt != 2'd3) se0_nxt = se0_cnt + 2'd1;
        end else if (line == LS_J && se0_cnt != 2'd0) begin
          state_nxt = ST_IDLE;
          end_evt   = 1'b1;
        end else begin
          se0_nxt = 2'd0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state          <= ST_IDLE;
      zero_cnt       <= 4'd0;
      se0_cnt        <= 2'd0;
      bstr_out       <= 1'b0;
      bstr_out_valid <= 1'b0;
      pkt_start      <= 1'b0;
      pkt_end        <= 1'b0;
      rx_err         <= 1'b0;
      rx_active      <= 1'b0;
    end else begin
      state          <= state_nxt;
      zero_cnt       <= zero_nxt;
      se0_cnt        <= se0_nxt;
      bstr_out_valid <= deliver;
      pkt_start      <= start_evt;
      pkt_end        <= end_evt;
      rx_err         <= err_evt;
      if (deliver) bstr_out <= dec_bit;
      // Stays high through the pkt_end cycle, drops on the next edge.
      if (start_evt) begin
        rx_active <= 1'b1;
      end else if (pkt_end) begin
        rx_active <= 1'b0;
      end
    end
  end

`ifdef NRZI_DEC_UNSTUFF_EN
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      ones_cnt  <= 3'd0;
      stuffed_q <= 6'd0;
    end else begin
      ones_cnt <= ones_nxt;
      if (start_evt) begin
        stuffed_q <= 6'd0;
      end else if (drop && stuffed_q != 6'h3F) begin
        stuffed_q <= stuffed_q + 6'd1;
      end
    end
  end

  assign stuffed_out = stuffed_q;
`else
  assign stuffed_out = 6'd0;
`endif

endmodule

// File: tb/tb_nrzi_dec.sv
// tb/tb_nrzi_dec.sv - randomized scoreboard bench for nrzi_dec; model follows NRZI_DEC_UNSTUFF_EN
module tb_nrzi_dec;
  import usb_pkg::*;

  logic       clk = 1'b0;
  logic       rst_b = 1'b1;
  logic       dp = 1'b1;
  logic       dm = 1'b0;
  logic       bstr_out, bstr_out_valid, pkt_start, pkt_end, rx_err, rx_active;
  logic [5:0] stuffed_out;

  nrzi_dec dut (
    .clk            (clk),
    .rst_b          (rst_b),
    .dp             (dp),
    .dm             (dm),
    .bstr_out       (bstr_out),
    .bstr_out_valid (bstr_out_valid),
    .pkt_start      (pkt_start),
    .pkt_end        (pkt_end),
    .rx_err         (rx_err),
    .rx_active      (rx_active),
    .stuffed_out    (stuffed_out)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] EV_START   = 3'b100;
  localparam logic [2:0] EV_END     = 3'b010;
  localparam logic [2:0] EV_ERR     = 3'b001;
  localparam logic [2:0] EV_END_ERR = 3'b011;

  typedef struct {
    logic [2:0] code;
    int         stuffed;
  } evt_t;

  int   n_checks = 0;
  int   n_fail = 0;
  logic exp_bits[$];
  evt_t exp_evt[$];
  bit   cur_k = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  initial begin : monitor
    logic last_bit;
    evt_t e;
    last_bit = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_b) begin
        last_bit = 1'b0;
      end else begin
        if (bstr_out_valid) begin
          check("bit_expected", exp_bits.size() != 0, 1);
          if (exp_bits.size() != 0) begin
            last_bit = exp_bits.pop_front();
            check("bstr_out", bstr_out, last_bit);
          end
        end else begin
          check("bstr_out_hold", bstr_out, last_bit);
        end
        if (pkt_start || pkt_end || rx_err) begin
          check("event_expected", exp_evt.size() != 0, 1);
          if (exp_evt.size() != 0) begin
            e = exp_evt.pop_front();
            check("event_code", {pkt_start, pkt_end, rx_err}, e.code);
            check("stuffed_out", stuffed_out, e.stuffed);
            check("rx_active_in_pkt", rx_active, 1);
          end
        end
      end
    end
  end

  task automatic drive(input line_state_t ls);
    @(negedge clk);
    case (ls)
      LS_J:    {dp, dm} = 2'b10;
      LS_K:    {dp, dm} = 2'b01;
      LS_SE0:  {dp, dm} = 2'b00;
      default: {dp, dm} = 2'b11;
    endcase
    if (ls == LS_J) cur_k = 1'b0;
    else if (ls == LS_K) cur_k = 1'b1;
  endtask

  task automatic send_bit(input bit b);
    if (!b) cur_k = ~cur_k;
    drive(cur_k ? LS_K : LS_J);
  endtask

  // Expected output of one packet from its post-SYNC items (0/1 data bits, 2 = SE1).
  task automatic predict(input int items[$], input bit has_eop, input int eop_kind);
    int run;
    int stuffed;
    bit err;
    run = 1;
    stuffed = 0;
    err = 1'b0;
    exp_evt.push_back('{EV_START, 0});
    for (int i = 0; i < items.size() && !err; i++) begin
      if (items[i] == 2) begin
        exp_evt.push_back('{EV_ERR, stuffed});
        err = 1'b1;
      end
`ifdef NRZI_DEC_UNSTUFF_EN
      else if (run == 6) begin
        if (items[i] == 0) begin
          stuffed = (stuffed == 63) ? 63 : stuffed + 1;
          run = 0;
        end else begin
          exp_evt.push_back('{EV_ERR, stuffed});
          err = 1'b1;
        end
      end
`endif
      else begin
        exp_bits.push_back(items[i] != 0);
        run = (items[i] != 0) ? run + 1 : 0;
      end
    end
    if (has_eop) begin
      if (err) exp_evt.push_back('{EV_END, stuffed});
      else if (eop_kind == 1 || eop_kind == 3) exp_evt.push_back('{EV_END_ERR, stuffed});
      else exp_evt.push_back('{EV_END, stuffed});
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    check("bits_drained_at_reset", exp_bits.size(), 0);
    check("events_drained_at_reset", exp_evt.size(), 0);
    rst_b = 1'b0;
    #1;
    check("outputs_in_reset", {bstr_out, bstr_out_valid, pkt_start, pkt_end, rx_err, rx_active, stuffed_out}, 0);
    {dp, dm} = 2'b10;
    cur_k = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    rst_b = 1'b1;
  endtask

  // abort_at >= 0: reset after that many items instead of sending EOP.
  task automatic send_packet(input int items[$], input int eop_kind, input int abort_at);
    int sent[$];
    repeat ($urandom_range(2, 5)) drive(LS_J);
    check("rx_active_idle", rx_active, 0);
    for (int i = 0; i < items.size(); i++)
      if (abort_at < 0 || i < abort_at) sent.push_back(items[i]);
    predict(sent, abort_at < 0, eop_kind);
    repeat (7) send_bit(1'b0);
    send_bit(1'b1);
    foreach (sent[i]) begin
      if (sent[i] == 2) drive(LS_SE1);
      else send_bit(sent[i] != 0);
    end
    if (abort_at >= 0) begin
      do_reset();
    end else begin
      case (eop_kind)
        0: begin drive(LS_SE0); drive(LS_SE0); drive(LS_J); end
        1: begin drive(LS_SE0); drive(LS_J); end
        2: begin repeat (4) drive(LS_SE0); drive(LS_J); end
        default: begin
          drive(LS_SE0); drive(LS_SE1); drive(LS_J);
          drive(LS_SE0); drive(LS_J);
        end
      endcase
    end
  endtask

  task automatic send_bad_sync(input int nz);
    repeat ($urandom_range(2, 5)) drive(LS_J);
    repeat (nz) send_bit(1'b0);
    send_bit(1'b1);
    repeat (3) drive(LS_J);
  endtask

  task automatic push_bits(inout int items[$], input logic [31:0] v, input int n);
    for (int i = 0; i < n; i++) items.push_back(int'(v[i]));
  endtask

  initial begin : stim
    int items[$];
    int len, mode, run, b, eop_kind, abort_at;
    #1;
    rst_b = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_state", {bstr_out, bstr_out_valid, pkt_start, pkt_end, rx_err, rx_active, stuffed_out}, 0);
    #2;
    rst_b = 1'b1;

    items.delete(); push_bits(items, 32'h2D, 8); send_packet(items, 0, -1);
    items.delete(); push_bits(items, 32'h5F, 7); send_packet(items, 0, -1);
    items.delete(); push_bits(items, 32'hBF, 8); send_packet(items, 0, -1);
    items.delete(); push_bits(items, 32'h7F, 9); send_packet(items, 0, -1);
    send_bad_sync(6);
    items.delete(); push_bits(items, 32'h6, 4); send_packet(items, 1, -1);
    items.delete(); push_bits(items, 32'h2D, 8); send_packet(items, 0, 3);
    items.delete(); push_bits(items, 32'hA5, 8); send_packet(items, 2, -1);
    items.delete(); push_bits(items, 32'h3, 4); items.push_back(2); send_packet(items, 3, -1);

    for (int p = 0; p < 80; p++) begin
      if ($urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 3))
          0: send_bad_sync(8);
          1: send_bad_sync(9);
          default: send_bad_sync($urandom_range(1, 6));
        endcase
      end else begin
        items.delete();
        len = $urandom_range(0, 24);
        mode = $urandom_range(0, 2);
        run = 1;
        for (int i = 0; i < len; i++) begin
          b = ($urandom_range(0, 3) != 0) ? 1 : 0;
          if (mode == 1 && run == 6) begin
            items.push_back(0);
            run = 0;
          end
          if (mode == 2 && $urandom_range(0, 19) == 0) items.push_back(2);
          items.push_back(b);
          run = (b != 0) ? run + 1 : 0;
        end
        eop_kind = $urandom_range(0, 3);
        abort_at = ($urandom_range(0, 9) == 0) ? $urandom_range(0, items.size()) : -1;
        send_packet(items, eop_kind, abort_at);
      end
    end

    repeat (10) drive(LS_J);
    check("bits_left_at_end", exp_bits.size(), 0);
    check("events_left_at_end", exp_evt.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
